// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and per-channel state for the timer_bank.
// Register offsets are the low nibble of the bus address; the upper
// three address bits select the channel.
package timer_pkg;

    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_STAT = 4'd1;
    localparam logic [3:0] REG_CNT  = 4'd4;
    localparam logic [3:0] REG_CMP  = 4'd8;
    localparam logic [3:0] REG_CAP  = 4'd12;

    localparam int CTRL_EN_B   = 0;
    localparam int CTRL_PER_B  = 1;
    localparam int CTRL_IRQ_B  = 2;
    localparam int CTRL_LOAD_B = 4;

    localparam int STAT_PEND_B = 0;
    localparam int STAT_CAP_B  = 1;

    // Storage is sized for the widest legal counter; narrower builds keep
    // the unused upper bits at zero so they fold away in synthesis.
    localparam int CNT_MAX_W = 32;

    typedef struct packed {
        logic                 en;
        logic                 periodic;
        logic                 irq_en;
        logic                 pending;
        logic                 cap_flag;
        logic [CNT_MAX_W-1:0] cnt;
        logic [CNT_MAX_W-1:0] cmp;
        logic [CNT_MAX_W-1:0] shadow;
        logic [CNT_MAX_W-1:0] snap;
        logic [CNT_MAX_W-1:0] cap;
    } tmr_ch_t;

    // Select byte b (0 = LSB) of a counter-sized word.
    function automatic logic [7:0] byte_of(input logic [CNT_MAX_W-1:0] v,
                                           input logic [1:0] b);
        return v[{b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/timer_bank_tick_gen.sv
// tick_gen: free-running prescaler shared by every timer channel.
// Counts 0..DIV-1 and raises tick_o for the single clk in which the
// count sits at DIV-1.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int            PW   = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // Next prescaler value: wrap to zero after the last count.
    always_comb begin
        pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
    end

    // Prescaler register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick_o = (pre_q == LAST);

endmodule

// File: rtl/timer_bank.sv
// timer_bank: CH_NUM independent up-counters on one prescaled tick, each
// with enable, one-shot/periodic mode, compare match, interrupt and an
// atomic multi-byte snapshot read through reg 4.
// Optional build macro TIMER_CAPTURE_EN adds a synchronised capture input
// per channel; without it cap_in_i is ignored and capture reads zero.
module timer_bank
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int CH_NUM  = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_i,
    input  logic [6:0]        addr_i,
    input  logic [7:0]        dati_i,
    input  logic              we_stb_i,
    input  logic              oe_stb_i,
    output logic [7:0]        dato_o,
    output logic              irq_o,
    output logic [CH_NUM-1:0] irq_vec_o,
    input  logic [CH_NUM-1:0] cap_in_i
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int NB  = CNT_W / 8;
    localparam logic [2:0] NB3 = 3'(NB);
    localparam logic [CNT_MAX_W-1:0] CNT_MASK =
        (CNT_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << CNT_W) - 64'd1);

    if (DIV < 2) begin : g_bad_div
        $error("timer_bank: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch
        $error("timer_bank: CH_NUM must be 1..8");
    end
    if (CNT_W != 8 && CNT_W != 16 && CNT_W != 24 && CNT_W != 32) begin : g_bad_w
        $error("timer_bank: CNT_W must be 8, 16, 24 or 32");
    end

    logic       tick;
    logic [2:0] ch_sel;
    logic [3:0] reg_sel;
    logic [1:0] reg_grp;
    logic [1:0] reg_b;
    logic       byte_ok;

    assign ch_sel  = addr_i[6:4];
    assign reg_sel = addr_i[3:0];
    assign reg_grp = reg_sel[3:2];
    assign reg_b   = reg_sel[1:0];
    assign byte_ok = {1'b0, reg_b} < NB3;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    tmr_ch_t           ch_view [CH_NUM];
    logic [CH_NUM-1:0] irq_src;

`ifndef TIMER_CAPTURE_EN
    logic unused_cap_in;
    assign unused_cap_in = ^cap_in_i;
`endif

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        tmr_ch_t              q;
        tmr_ch_t              d;
        logic                 hit;
        logic                 wr_hit;
        logic                 ld;
        logic                 snap_hit;
        logic                 cap_rise;
        logic [CNT_MAX_W-1:0] nxt;

        assign hit      = sel_i && (ch_sel == 3'(i));
        assign wr_hit   = hit && we_stb_i;
        assign ld       = wr_hit && (reg_sel == REG_CTRL) && dati_i[CTRL_LOAD_B];
        assign snap_hit = hit && oe_stb_i && (reg_sel == REG_CNT);
        assign nxt      = (q.cnt + 32'd1) & CNT_MASK;

`ifdef TIMER_CAPTURE_EN
        logic [2:0] cap_sync_q;

        // Two synchroniser flops plus one history flop for rising-edge detect.
        always_ff @(posedge clk) begin
            if (rst) begin
                cap_sync_q <= '0;
            end else begin
                cap_sync_q <= {cap_sync_q[1:0], cap_in_i[i]};
            end
        end

        assign cap_rise = cap_sync_q[1] & ~cap_sync_q[2];
`else
        assign cap_rise = 1'b0;
`endif

        // Channel next state; later assignments win, so hardware sets
        // (match, capture) override same-cycle CPU clears.
        always_comb begin
            d = q;
            if (wr_hit && reg_grp == REG_CMP[3:2] && byte_ok) begin
                d.cmp[{reg_b, 3'b000} +: 8] = dati_i;
            end
            if (wr_hit && reg_grp == REG_CNT[3:2] && byte_ok) begin
                d.shadow[{reg_b, 3'b000} +: 8] = dati_i;
            end
            if (wr_hit && reg_sel == REG_STAT) begin
                if (dati_i[STAT_PEND_B]) d.pending = 1'b0;
                if (dati_i[STAT_CAP_B])  d.cap_flag = 1'b0;
            end
            if (wr_hit && reg_sel == REG_CTRL) begin
                d.en       = dati_i[CTRL_EN_B];
                d.periodic = dati_i[CTRL_PER_B];
                d.irq_en   = dati_i[CTRL_IRQ_B];
                if (dati_i[CTRL_LOAD_B]) d.cnt = q.shadow;
            end
            // A load in the same cycle suppresses the tick entirely.
            if (tick && q.en && !ld) begin
                if (nxt == q.cmp) begin
                    d.pending = 1'b1;
                    if (q.periodic) begin
                        d.cnt = '0;
                    end else begin
                        d.cnt = nxt;
                        d.en  = 1'b0;
                    end
                end else begin
                    d.cnt = nxt;
                end
            end
            // Snapshot holds the value whose low byte was just returned.
            if (snap_hit) d.snap = q.cnt;
            if (cap_rise) begin
                d.cap      = q.cnt;
                d.cap_flag = 1'b1;
            end
        end

        // Channel state register.
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end

        assign ch_view[i] = q;
        assign irq_src[i] = q.pending & q.irq_en;
    end

    logic              irq_q;
    logic [CH_NUM-1:0] irq_vec_q;

    // Interrupt outputs lag the pending bits by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= 1'b0;
            irq_vec_q <= '0;
        end else begin
            irq_q     <= |irq_src;
            irq_vec_q <= irq_src;
        end
    end

    assign irq_o     = irq_q;
    assign irq_vec_o = irq_vec_q;

    logic [7:0] rd_data;

    // Combinational read mux; unpopulated channels and bytes return zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (ch_sel == 3'(k)) begin
                if (reg_sel == REG_CTRL) begin
                    rd_data[CTRL_EN_B]  = ch_view[k].en;
                    rd_data[CTRL_PER_B] = ch_view[k].periodic;
                    rd_data[CTRL_IRQ_B] = ch_view[k].irq_en;
                end else if (reg_sel == REG_STAT) begin
                    rd_data[STAT_PEND_B] = ch_view[k].pending;
                    rd_data[STAT_CAP_B]  = ch_view[k].cap_flag;
                end else if (byte_ok) begin
                    if (reg_grp == REG_CNT[3:2]) begin
                        rd_data = (reg_b == 2'd0) ? byte_of(ch_view[k].cnt, reg_b)
                                                  : byte_of(ch_view[k].snap, reg_b);
                    end else if (reg_grp == REG_CMP[3:2]) begin
                        rd_data = byte_of(ch_view[k].cmp, reg_b);
                    end else if (reg_grp == REG_CAP[3:2]) begin
                        rd_data = byte_of(ch_view[k].cap, reg_b);
                    end
                end
            end
        end
    end

    assign dato_o = rd_data;

endmodule
